fp_mul_share_arb: RTL

- Round-robin scheduler that shares one external LANES-wide pipelined FP32 multiplier array between NUM_REQ ray/triangle intersection engines.
- Each engine presents one LANES-wide operand bundle per stage (cross product, dot product, denominator), e.g. 6 products.
- The block arbitrates, issues operands, tracks ownership through the fixed multiplier latency, and routes products back to the owning engine.
- Saves area versus one multiplier bank per engine.

---
 rtl/rt_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_mul_share_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// Shared ray/triangle types: FP32 word, lane bundle, multiplier owner tag
// and the default multiplier latency used by the engine sequencers.
package rt_pkg;

  localparam int FP32_W      = 32;
  localparam int LANES_DEF   = 6;
  localparam int MUL_LAT_DEF = 3;
  // Wide enough for the largest supported engine count (8).
  localparam int TAG_IDX_W   = 3;

  typedef logic [FP32_W-1:0] fp32_t;
  typedef fp32_t [LANES_DEF-1:0] lane_bundle_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } owner_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i with wrap,
// grants the first active request. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  int               pos;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/fp_mul_share_arb.sv
// Shares one pipelined FP32 multiplier array between NUM_REQ engines.
// Optional statistics counters are enabled with `define FP_MUL_ARB_STATS_EN.
module fp_mul_share_arb
  import rt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LANES   = LANES_DEF,
  parameter int DATA_W  = FP32_W,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*LANES*DATA_W-1:0]   req_a_i,
  input  logic [NUM_REQ*LANES*DATA_W-1:0]   req_b_i,
`ifdef FP_MUL_ARB_STATS_EN
  input  logic                              stats_clr_i,
  output logic [NUM_REQ*16-1:0]             grant_cnt_o,
  output logic [15:0]                       busy_cnt_o,
`endif
  output logic                              mul_valid_o,
  output logic [LANES*DATA_W-1:0]           mul_a_o,
  output logic [LANES*DATA_W-1:0]           mul_b_o,
  input  logic [LANES*DATA_W-1:0]           mul_p_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [LANES*DATA_W-1:0]           rsp_data_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BUN_W = LANES * DATA_W;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [BUN_W-1:0]   gnt_a, gnt_b;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               mul_valid_q;
  logic [BUN_W-1:0]   mul_a_q, mul_b_q;
  owner_tag_t         tag_q [MUL_LAT+1];
  owner_tag_t         tag_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [BUN_W-1:0]   rsp_data_q, rsp_data_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // A grant only exists for a valid requester, so gnt_valid is the handshake.
  assign req_ready_o = gnt;
  assign gnt_a       = req_a_i[int'(gnt_idx)*BUN_W +: BUN_W];
  assign gnt_b       = req_b_i[int'(gnt_idx)*BUN_W +: BUN_W];

  always_comb begin
    ptr_d       = ptr_q;
    tag_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (gnt_valid) begin
      ptr_d     = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      tag_d.valid = 1'b1;
      tag_d.idx   = TAG_IDX_W'(gnt_idx);
    end
    // The last tag stage lines up with the product leaving the multiplier.
    if (tag_q[MUL_LAT].valid) begin
      rsp_valid_d[tag_q[MUL_LAT].idx[IDX_W-1:0]] = 1'b1;
      rsp_data_d = mul_p_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_valid_q <= gnt_valid;
      if (gnt_valid) begin
        mul_a_q <= gnt_a;
        mul_b_q <= gnt_b;
      end
      tag_q[0] <= tag_d;
      for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mul_valid_o = mul_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

`ifdef FP_MUL_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] busy_cnt_q;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) grant_cnt_q[k] <= '0;
    end else if (stats_clr_i) begin
      busy_cnt_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) grant_cnt_q[k] <= '0;
    end else begin
      if (mul_valid_q && busy_cnt_q != 16'hFFFF) busy_cnt_q <= busy_cnt_q + 16'd1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt[k] && grant_cnt_q[k] != 16'hFFFF) grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_cnt_o[k*16 +: 16] = grant_cnt_q[k];
  end
  assign busy_cnt_o = busy_cnt_q;
`endif

endmodule
